// File: rtl/word_block_assembler_pkg.sv
// Shared types and sizing helpers for the word block assembler.
//   asm_state_t : assembler FSM state encoding (2 bits)
//   *_DEF       : default parameter values used by the top and the interface
//   BLOCK_W     : assembled block width for the default geometry
//   cnt_w()     : width of a counter that indexes 0..words-1
package blk_asm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } asm_state_t;

  localparam int WORD_W_DEF = 32;
  localparam int WORDS_DEF  = 4;
  localparam int CNT_W_DEF  = 16;
  localparam int BLOCK_W    = WORDS_DEF * WORD_W_DEF;

  // A single-word block still needs a 1-bit index counter.
  function automatic int cnt_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/word_block_assembler_if.sv
// Bus bundle between the input FIFO, the assembler and the processing core.
//   FIFO side : in_ready (data_ready), in_data (dout), rd_en
//   Core side : block_data, block_valid, block_ready
//   master    : the assembler (reads the FIFO, offers blocks)
//   slave     : the environment (FIFO plus consuming core)
interface word_block_assembler_if #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
);
  logic                      in_ready;
  logic [WORD_W-1:0]         in_data;
  logic                      rd_en;
  logic [WORDS*WORD_W-1:0]   block_data;
  logic                      block_valid;
  logic                      block_ready;

  modport master (
    input  in_ready, in_data, block_ready,
    output rd_en, block_data, block_valid
  );

  modport slave (
    output in_ready, in_data, block_ready,
    input  rd_en, block_data, block_valid
  );
endinterface

// File: rtl/word_block_assembler_shift_reg.sv
// word_shift_reg: WORDS-deep word shift register with a parallel view.
//   clk, rst  : clock, asynchronous active-high reset (clears all words)
//   shift_en  : shift word_in in at the LSB end, pushing older words up
//   word_in   : incoming word
//   block_out : all words in parallel; the oldest word sits in the MSBs
module word_shift_reg #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en,
  input  logic [WORD_W-1:0]       word_in,
  output logic [WORDS*WORD_W-1:0] block_out
);

  logic [WORDS-1:0][WORD_W-1:0] words_q;

  for (genvar g = 0; g < WORDS; g++) begin : g_word
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        words_q[g] <= '0;
      end else if (shift_en) begin
        if (g == 0) words_q[g] <= word_in;
        else        words_q[g] <= words_q[(g > 0) ? g-1 : 0];
      end
    end
  end

  assign block_out = words_q;

endmodule

// File: rtl/word_block_assembler.sv
// word_block_assembler: drains WORDS words from the input FIFO whenever it
// reports a full set, packs them into one block (first word in the MSBs)
// and offers the block to the processing core over valid/ready.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : FIFO read side (in_ready, in_data, rd_en) and block
//                handshake (block_data, block_valid, block_ready)
//   busy       : FSM is outside IDLE
//   blk_count  : completed block handshakes, wraps modulo 2^CNT_W
module word_block_assembler
  import blk_asm_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int WORDS  = WORDS_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  word_block_assembler_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     blk_count
);

  localparam int             IDX_W = cnt_w(WORDS);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  asm_state_t       state, state_nxt;
  logic [IDX_W-1:0] req_cnt, req_cnt_nxt;
  logic [IDX_W-1:0] cap_cnt;
  logic             rd_en, rd_en_nxt;
  logic             rd_en_q;
  logic             block_valid;
  logic             capture;
  logic             last_cap;
  logic             hs;
  logic [WORDS*WORD_W-1:0] block_data;

  // The FIFO presents a word one cycle after it sees rd_en, so the
  // delayed request doubles as the capture strobe.
  assign capture  = rd_en_q;
  assign last_cap = capture && (cap_cnt == LAST);
  assign hs       = block_valid && bus.block_ready;

  // rd_en is registered, so it is decided one cycle ahead: the edge that
  // enters FETCH also raises rd_en, giving exactly WORDS request cycles.
  always_comb begin
    state_nxt   = state;
    req_cnt_nxt = req_cnt;
    rd_en_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_ready) begin
          state_nxt = FETCH;
          rd_en_nxt = 1'b1;
        end
      end
      FETCH: begin
        // in_ready is ignored here: the FIFO drops it while being read.
        if (req_cnt == LAST) begin
          state_nxt   = DRAIN;
          req_cnt_nxt = '0;
        end else begin
          req_cnt_nxt = req_cnt + 1'b1;
          rd_en_nxt   = 1'b1;
        end
      end
      DRAIN: begin
        if (last_cap) state_nxt = HOLD;
      end
      HOLD: begin
        // Backpressure keeps us here with rd_en low, so no FIFO reads.
        if (bus.block_ready) begin
          if (bus.in_ready) begin
            state_nxt = FETCH;
            rd_en_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt   = IDLE;
        req_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      req_cnt <= '0;
      rd_en   <= 1'b0;
      rd_en_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_cnt <= req_cnt_nxt;
      rd_en   <= rd_en_nxt;
      rd_en_q <= rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_cnt <= '0;
    end else if (capture) begin
      cap_cnt <= (cap_cnt == LAST) ? '0 : cap_cnt + 1'b1;
    end
  end

  // Valid rises with the final capture and falls on the handshake; the
  // two cannot coincide because HOLD issues no reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_valid <= 1'b0;
    end else if (last_cap) begin
      block_valid <= 1'b1;
    end else if (hs) begin
      block_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     blk_count <= '0;
    else if (hs) blk_count <= blk_count + 1'b1;
  end

  word_shift_reg #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (capture),
    .word_in   (bus.in_data),
    .block_out (block_data)
  );

  assign bus.rd_en       = rd_en;
  assign bus.block_valid = block_valid;
  assign bus.block_data  = block_data;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_word_block_assembler.sv
// Bench for word_block_assembler: a queue-based FIFO model feeds the DUT,
// every block pushed into the FIFO is also queued as the expected block,
// and a negedge monitor compares each handshake against that queue.
module tb_word_block_assembler;
  localparam int WORD_W  = 32;
  localparam int WORDS   = 4;
  localparam int CNT_W   = 2;
  localparam int BLOCK_W = WORDS * WORD_W;

  logic             clk;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] blk_count;

  word_block_assembler_if #(.WORD_W(WORD_W), .WORDS(WORDS)) bus ();

  word_block_assembler #(
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .blk_count (blk_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [WORD_W-1:0]  fifo_q[$];
  logic [BLOCK_W-1:0] exp_q[$];
  int                 cnt_log[$];
  int pushed   = 0;
  int popped   = 0;
  int rd_total = 0;
  int hs_total = 0;
  int exp_cnt  = 0;
  bit cnt_pend = 0;

  task automatic chk(input string name, input logic [BLOCK_W-1:0] act,
                     input logic [BLOCK_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: data_ready whenever a full set of words is stored.
  assign bus.in_ready = ((pushed - popped) >= WORDS);

  always @(posedge clk) begin
    if (!rst && bus.rd_en) begin
      rd_total++;
      if (fifo_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fifo_underflow: read from empty FIFO (t=%0t)", $time);
      end else begin
        bus.in_data <= fifo_q.pop_front();
        popped++;
      end
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt  = 0;
      cnt_pend = 0;
    end else begin
      if (cnt_pend) begin
        chk("blk_count_after_hs", BLOCK_W'(blk_count), BLOCK_W'(exp_cnt % (1 << CNT_W)));
        cnt_log.push_back(int'(blk_count));
        cnt_pend = 0;
      end
      if (bus.block_valid && bus.block_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_block: got %0h expected none", bus.block_data);
        end else begin
          chk("block_data", bus.block_data, exp_q.pop_front());
        end
        exp_cnt++;
        hs_total++;
        cnt_pend = 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [BLOCK_W-1:0] blk);
    for (int i = 0; i < WORDS; i++)
      fifo_q.push_back(blk[(WORDS-1-i)*WORD_W +: WORD_W]);
    exp_q.push_back(blk);
    pushed += WORDS;
  endtask

  function automatic logic [BLOCK_W-1:0] rand_block();
    logic [BLOCK_W-1:0] b;
    for (int i = 0; i < WORDS; i++) b[i*WORD_W +: WORD_W] = $urandom;
    return b;
  endfunction

  task automatic wait_hs(input int target, input int budget);
    int k = 0;
    while (hs_total < target && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (hs_total < target) begin
      failures++;
      $display("FAIL wait_handshake: got %0d handshakes expected %0d", hs_total, target);
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!bus.block_valid && k < budget) begin
      step();
      k++;
    end
    chk("wait_block_valid", BLOCK_W'(bus.block_valid), BLOCK_W'(1));
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    pushed = popped;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    logic [BLOCK_W-1:0] hold;
    int p0, rd0, hs0;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};

    rst = 1'b1;
    bus.block_ready = 1'b0;
    bus.in_data = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    chk("reset_rd_en", BLOCK_W'(bus.rd_en), '0);
    chk("reset_block_valid", BLOCK_W'(bus.block_valid), '0);
    chk("reset_block_data", bus.block_data, '0);
    chk("reset_blk_count", BLOCK_W'(blk_count), '0);
    chk("reset_busy", BLOCK_W'(busy), '0);

    // Single block with exact timing: pushed in cycle T
    bus.block_ready = 1'b1;
    push_block({32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    for (int k = 1; k <= WORDS; k++) begin
      step();
      chk("single_rd_en_high", BLOCK_W'(bus.rd_en), BLOCK_W'(1));
      chk("single_valid_low", BLOCK_W'(bus.block_valid), '0);
    end
    step();
    chk("single_rd_en_done", BLOCK_W'(bus.rd_en), '0);
    chk("single_valid_t5", BLOCK_W'(bus.block_valid), '0);
    chk("single_busy", BLOCK_W'(busy), BLOCK_W'(1));
    step();
    chk("single_valid_t6", BLOCK_W'(bus.block_valid), BLOCK_W'(1));
    chk("single_data_t6", bus.block_data,
        {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
    step();
    chk("single_count_t7", BLOCK_W'(blk_count), BLOCK_W'(1));
    chk("single_valid_t7", BLOCK_W'(bus.block_valid), '0);
    chk("single_idle_t7", BLOCK_W'(busy), '0);

    // Backpressure with in_ready held high
    bus.block_ready = 1'b0;
    hs0 = hs_total;
    push_block(rand_block());
    push_block(rand_block());
    wait_valid(20);
    hold = bus.block_data;
    p0 = popped;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_data_stable", bus.block_data, hold);
      chk("bp_rd_en_low", BLOCK_W'(bus.rd_en), '0);
      chk("bp_no_pops", BLOCK_W'(popped), BLOCK_W'(p0));
      chk("bp_in_ready", BLOCK_W'(bus.in_ready), BLOCK_W'(1));
    end
    bus.block_ready = 1'b1;
    step();
    chk("bp_direct_fetch", BLOCK_W'(bus.rd_en), BLOCK_W'(1));
    wait_hs(hs0 + 2, 30);
    step();
    chk("bp_count", BLOCK_W'(blk_count), BLOCK_W'(3));

    // Reset after two captures of a fetch
    push_block(rand_block());
    for (int k = 0; k < 4; k++) step();
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_en", BLOCK_W'(bus.rd_en), '0);
    chk("rst_block_valid", BLOCK_W'(bus.block_valid), '0);
    chk("rst_blk_count", BLOCK_W'(blk_count), '0);
    chk("rst_busy", BLOCK_W'(busy), '0);
    fifo_q.delete();
    exp_q.delete();
    pushed = popped;
    step();
    step();
    rst = 1'b0;
    step();

    // Fresh block after reset; in_ready falls at T+2 as the FIFO drains
    rd0 = rd_total;
    hs0 = hs_total;
    push_block(rand_block());
    step();
    step();
    chk("drop_in_ready_low", BLOCK_W'(bus.in_ready), '0);
    chk("drop_rd_en_continues", BLOCK_W'(bus.rd_en), BLOCK_W'(1));
    wait_hs(hs0 + 1, 20);
    step();
    chk("drop_rd_cycles", BLOCK_W'(rd_total - rd0), BLOCK_W'(WORDS));
    chk("post_rst_count", BLOCK_W'(blk_count), BLOCK_W'(1));

    // Back-to-back: three blocks queued at once
    do_reset();
    rd0 = rd_total;
    hs0 = hs_total;
    for (int b = 0; b < 3; b++) push_block(rand_block());
    wait_hs(hs0 + 3, 60);
    step();
    chk("b2b_count", BLOCK_W'(blk_count), BLOCK_W'(3));
    chk("b2b_rd_cycles", BLOCK_W'(rd_total - rd0), BLOCK_W'(3 * WORDS));

    // Counter wrap with a 2-bit counter
    do_reset();
    cnt_log.delete();
    hs0 = hs_total;
    for (int b = 0; b < 5; b++) push_block(rand_block());
    wait_hs(hs0 + 5, 100);
    step();
    step();
    for (int i = 0; i < 5; i++)
      chk("wrap_seq", BLOCK_W'((i < cnt_log.size()) ? cnt_log[i] : -1), BLOCK_W'(exp_seq[i]));

    // Randomized traffic and backpressure
    for (int c = 0; c < 600; c++) begin
      bus.block_ready = ($urandom_range(0, 3) != 0);
      if ((pushed - popped) < 2 * WORDS && $urandom_range(0, 3) == 0)
        push_block(rand_block());
      step();
    end
    bus.block_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) step();
    step();
    step();
    chk("rand_all_blocks_out", BLOCK_W'(exp_q.size()), '0);
    chk("rand_fifo_empty", BLOCK_W'(pushed - popped), '0);
    chk("rand_idle", BLOCK_W'(busy), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_block_assembler.md
Name: word_block_assembler

Overview:
- Downstream consumer of the 4-word input FIFO stage.
- Waits for the FIFO's `data_ready`, then issues a burst of `rd_en` pulses and captures the returned words.
- Packs the words into one WORDS*WORD_W-bit block and presents it to the processing core over a valid/ready handshake.
- Counts completed blocks for debug and status.

Parameters:
- WORD_W, 32, width of one word from the input FIFO
- WORDS, 4, words per block; must equal the FIFO fill threshold
- CNT_W, 16, width of the completed-block counter

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- in_ready  input  1  from the FIFO `data_ready`: WORDS words available
- in_data  input  WORD_W  from the FIFO `dout`; valid the cycle after `rd_en` is sampled high
- rd_en  output  1  read request to the FIFO; registered
- block_data  output  WORDS*WORD_W  assembled block; first word in the MSBs
- block_valid  output  1  block_data valid
- block_ready  input  1  downstream accepts the block
- busy  output  1  high in any state other than IDLE
- blk_count  output  CNT_W  number of completed handshakes; wraps modulo 2^CNT_W

Behaviour:
- Reset values: state IDLE, rd_en=0, block_valid=0, block_data=0, blk_count=0, busy=0, internal counters 0.
- Reset mid-operation aborts any partial block; nothing is emitted.
- States:
  - IDLE: if in_ready=1 → FETCH.
  - FETCH: rd_en=1 for exactly WORDS consecutive cycles, counted by req_cnt (0..WORDS-1). After the last request → DRAIN.
  - DRAIN: wait for the final word capture → HOLD.
  - HOLD: block_valid=1; block_data stable.
- HOLD exits:
  - block_ready=1 and in_ready=0 → IDLE.
  - block_ready=1 and in_ready=1 → FETCH directly (back-to-back operation).
  - block_ready=0 → stay in HOLD with rd_en=0. Backpressure must not cause any FIFO reads.
- Capture pipeline:
  - rd_en_q is rd_en delayed by one cycle.
  - On each clock edge where rd_en_q=1, shift in_data into block_data from the LSB side: `block_data <= {block_data[WORDS*WORD_W-WORD_W-1:0], in_data}`.
  - After WORDS captures, word 0 occupies bits [WORDS*WORD_W-1 : (WORDS-1)*WORD_W].
  - cap_cnt counts captures; the capture with cap_cnt = WORDS-1 sets block_valid at that edge.
- Timing, with in_ready sampled high at the end of cycle T:
  - rd_en high in cycles T+1..T+WORDS.
  - Captures at the ends of cycles T+2..T+WORDS+1.
  - block_valid high from cycle T+WORDS+2, i.e. cycle T+6 for WORDS=4.
- in_ready is ignored in FETCH and DRAIN. The upstream FIFO lowers data_ready during its read; this must not abort the fetch.
- block_valid falls on the edge where block_valid&&block_ready=1. blk_count increments on the same edge.
- block_data holds its last value after the handshake until overwritten by the next capture.
- busy = (state != IDLE).
- No X-checking of in_data; the block is synthesizable only.

Decomposition:
- Package `blk_asm_pkg`:
  - state enum {IDLE, FETCH, DRAIN, HOLD}, 2 bits.
  - localparam BLOCK_W = WORDS*WORD_W.
  - Counter width function $clog2(WORDS).
- One natural sub-module, `word_shift_reg` (parameters WORD_W, WORDS):
  - Inputs: shift enable, word in.
  - Output: parallel block.
  - Keeps the FSM file free of the datapath.

Test Plan:
- Single block:
  - Stimulus: after reset, FIFO model holds 0x11111111, 0x22222222, 0x33333333, 0x44444444; in_ready pulses at T; block_ready=1.
  - Required: rd_en high T+1..T+4; block_valid at T+6 with block_data=0x11111111_22222222_33333333_44444444; blk_count=1 one cycle later.
- Backpressure:
  - Stimulus: block_ready=0 for 10 cycles after block_valid; in_ready=1 throughout.
  - Required: block_data constant, rd_en stays 0, no FIFO pops.
  - Then block_ready=1 → direct HOLD→FETCH; rd_en rises on the next cycle.
- Back-to-back:
  - Stimulus: three consecutive blocks, block_ready=1 and in_ready=1 when sampled.
  - Required: 3 correct blocks; blk_count=3; exactly 12 rd_en cycles total.
- in_ready drop mid-fetch:
  - Stimulus: in_ready falls at T+2.
  - Required: rd_en still completes 4 cycles; block still emitted correctly.
- Reset mid-fetch:
  - Stimulus: rst asserted asynchronously after 2 captures.
  - Required: rd_en, block_valid, and blk_count immediately 0; state IDLE.
  - A following full block assembles correctly with no leftover words.
- Counter wrap:
  - Stimulus: CNT_W=2, five blocks.
  - Required: blk_count sequence 1, 2, 3, 0, 1.
